// File: rtl/dds_phase_amp_pipe.sv
// Phase-to-amplitude converter (quarter-wave sine ROM, square, sawtooth); 3-cycle latency, one sample/cycle, no backpressure.
// Define DDS_PTA_DITHER_EN to add LFSR phase dither ahead of the sine ROM address truncation.
module dds_phase_amp_pipe #(
  parameter int    PHASE_W  = 12,
  parameter int    LUT_AW   = 8,
  parameter int    AMP_W    = 10,
  parameter string SIN_FILE = "sin_quarter.hex"
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               phase_valid,
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         mode,
  output logic               data_valid,
  output logic [AMP_W-1:0]   data_out
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int PW    = LUT_AW + 2;
  localparam logic [AMP_W-1:0] MID = {1'b1, {(AMP_W-1){1'b0}}};

  if (PHASE_W < PW || SIN_FILE == "") begin : g_bad_cfg
    $error("dds_phase_amp_pipe: PHASE_W must be >= LUT_AW+2 and SIN_FILE must be named");
  end

  // ROM contents follow the same formula used to build SIN_FILE, evaluated at elaboration
  function automatic real sin_taylor(input real x);
    real term;
    real acc;
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic logic [AMP_W-2:0] rom_entry(input int k);
    real a;
    a = real'((1 << (AMP_W - 1)) - 1) *
        sin_taylor(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N));
    return (AMP_W-1)'(int'(a));
  endfunction

  logic [AMP_W-2:0] rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [AMP_W-2:0] ROM_V = rom_entry(k);
    assign rom[k] = ROM_V;
  end

  logic [PHASE_W-1:0] phase_eff;

`ifdef DDS_PTA_DITHER_EN
  localparam int DW = PHASE_W - PW;
  localparam logic [PHASE_W-1:0] DMASK = (PHASE_W'(1) << DW) - PHASE_W'(1);

  logic [15:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (phase_valid && mode == 2'd0) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign phase_eff = phase + (PHASE_W'(lfsr) & DMASK);
`else
  assign phase_eff = phase;
`endif

  logic [PW-1:0]     p_top;
  logic [1:0]        quad;
  logic [LUT_AW-1:0] addr;
  logic [AMP_W-1:0]  saw;
  logic [AMP_W-1:0]  byp;
  logic              unused_bits;

  assign p_top       = phase_eff[PHASE_W-1 -: PW];
  assign quad        = p_top[PW-1 -: 2];
  assign addr        = p_top[LUT_AW-1:0] ^ {LUT_AW{quad[0]}};
  assign unused_bits = ^phase_eff;

  if (PHASE_W >= AMP_W) begin : g_saw_trunc
    assign saw = phase[PHASE_W-1 -: AMP_W];
  end else begin : g_saw_pad
    assign saw = {phase, {(AMP_W-PHASE_W){1'b0}}};
  end

  always_comb begin
    byp = MID;
    case (mode)
      2'd1:    byp = phase[PHASE_W-1] ? '0 : '1;
      2'd2:    byp = saw;
      default: byp = MID;
    endcase
  end

  logic              s1_vld;
  logic [1:0]        s1_mode;
  logic              s1_neg;
  logic [LUT_AW-1:0] s1_addr;
  logic [AMP_W-1:0]  s1_byp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_mode <= 2'd0;
      s1_neg  <= 1'b0;
      s1_addr <= '0;
      s1_byp  <= MID;
    end else begin
      s1_vld <= phase_valid;
      if (phase_valid) begin
        s1_mode <= mode;
        s1_neg  <= quad[1];
        s1_addr <= addr;
        s1_byp  <= byp;
      end
    end
  end

  logic             s2_vld;
  logic [1:0]       s2_mode;
  logic             s2_neg;
  logic [AMP_W-2:0] s2_mag;
  logic [AMP_W-1:0] s2_byp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld  <= 1'b0;
      s2_mode <= 2'd0;
      s2_neg  <= 1'b0;
      s2_mag  <= '0;
      s2_byp  <= MID;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mode <= s1_mode;
        s2_neg  <= s1_neg;
        s2_mag  <= rom[s1_addr];
        s2_byp  <= s1_byp;
      end
    end
  end

  // Output only updates on valid samples, so bubbles leave the last sample on data_out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_valid <= 1'b0;
      data_out   <= MID;
    end else begin
      data_valid <= s2_vld;
      if (s2_vld) begin
        if (s2_mode == 2'd0) begin
          data_out <= s2_neg ? MID - {1'b0, s2_mag} : MID + {1'b0, s2_mag};
        end else begin
          data_out <= s2_byp;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_amp_pipe.sv
// Bench for dds_phase_amp_pipe at default parameters: per-cycle model comparison plus literal spot values.
module tb_dds_phase_amp_pipe;

  localparam int MAXC = 8192;
  localparam logic [9:0] MID = 10'd512;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        phase_valid;
  logic [11:0] phase;
  logic [1:0]  mode;
  logic        data_valid;
  logic [9:0]  data_out;

  dds_phase_amp_pipe dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .phase_valid(phase_valid),
    .phase      (phase),
    .mode       (mode),
    .data_valid (data_valid),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic       rec_vld [MAXC];
  logic       rec_rst [MAXC];
  logic [9:0] rec_dat [MAXC];
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic int golden_mag(input int k);
    real a;
    a = 511.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 512.0);
    return int'(a);
  endfunction

  function automatic logic [9:0] model(input logic [11:0] ph, input logic [1:0] md, input int dith);
    int p, q, k, m;
    case (md)
      2'd0: begin
        p = ((int'(ph) + dith) % 4096) / 4;
        q = p / 256;
        k = p % 256;
        if (q % 2 == 1) k = 255 - k;
        m = golden_mag(k);
        return (q >= 2) ? 10'(512 - m) : 10'(512 + m);
      end
      2'd1:    return (ph < 12'd2048) ? 10'd1023 : 10'd0;
      2'd2:    return 10'(int'(ph) / 4);
      default: return MID;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [11:0] ph, input logic [1:0] md, input logic rn);
    int dith;
    dith = 0;
    if (!rn) m_lfsr = 16'hACE1;
`ifdef DDS_PTA_DITHER_EN
    if (v && rn && md == 2'd0) begin
      dith   = int'(m_lfsr[1:0]);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif
    phase_valid  = v;
    phase        = ph;
    mode         = md;
    reset_n      = rn;
    rec_vld[cyc] = v;
    rec_rst[cyc] = rn;
    rec_dat[cyc] = model(ph, md, dith);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic v, input logic [11:0] ph, input logic [1:0] md, input logic rn);
    drive(v, ph, md, rn);
    tick();
  endtask

  // One isolated sample; its result must be on the outputs exactly three cycles later
  task automatic single(input string nm, input logic [11:0] ph, input logic [1:0] md, input logic [9:0] lit);
    step(1'b1, ph, md, 1'b1);
    step(1'b0, 12'h0, 2'd0, 1'b1);
    chk({nm, "_early"}, data_valid, 1'b0);
    step(1'b0, 12'h0, 2'd0, 1'b1);
    chk({nm, "_vld"}, data_valid, 1'b1);
    chk({nm, "_dat"}, data_out, lit);
    step(1'b0, 12'h0, 2'd0, 1'b1);
    chk({nm, "_one_cycle"}, data_valid, 1'b0);
  endtask

  logic       e_vld;
  logic [9:0] e_last = MID;
  logic       run_chk = 1'b0;

  always @(negedge clock) begin
    if (run_chk) begin
      int t;
      t = cyc;
      if (!rec_rst[t]) begin
        e_vld  = 1'b0;
        e_last = MID;
      end else if (t >= 3 && rec_vld[t-3] && rec_rst[t-3] && rec_rst[t-2] && rec_rst[t-1]) begin
        e_vld  = 1'b1;
        e_last = rec_dat[t-3];
      end else begin
        e_vld = 1'b0;
      end
      chk("model_vld", data_valid, e_vld);
      chk("model_dat", data_out, e_last);
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      rec_vld[i] = 1'b0;
      rec_rst[i] = 1'b0;
      rec_dat[i] = MID;
    end
    drive(1'b0, 12'h0, 2'd0, 1'b0);
    run_chk = 1'b1;
    tick();

    repeat (4) step(1'b0, 12'h0, 2'd0, 1'b0);
    chk("rst_dat", data_out, MID);
    chk("rst_vld", data_valid, 1'b0);
    repeat (3) step(1'b0, 12'h0, 2'd0, 1'b1);
    chk("rel_dat", data_out, MID);
    chk("rel_vld", data_valid, 1'b0);

    single("sin_000", 12'h000, 2'd0, 10'd514);
    single("sin_400", 12'h400, 2'd0, 10'd1023);
    single("sin_800", 12'h800, 2'd0, 10'd510);
    single("sin_C00", 12'hC00, 2'd0, 10'd1);
    single("saw_ABC", 12'hABC, 2'd2, 10'h2AF);
    single("sq_7FF",  12'h7FF, 2'd1, 10'd1023);
    single("sq_800",  12'h800, 2'd1, 10'd0);
    single("mode3",   12'h123, 2'd3, MID);

    begin
      logic       pat [6];
      logic [11:0] ph;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        ph = 12'(i * 12'h2A7 + 12'h155);
        step(pat[i], ph, 2'(i), 1'b1);
      end
      repeat (4) step(1'b0, 12'h0, 2'd0, 1'b1);
    end

    for (int i = 0; i < 4096; i++) step(1'b1, 12'(i), 2'd0, 1'b1);
    repeat (4) step(1'b0, 12'h0, 2'd0, 1'b1);

    step(1'b1, 12'h100, 2'd0, 1'b1);
    step(1'b1, 12'h200, 2'd2, 1'b1);
    step(1'b1, 12'h300, 2'd1, 1'b1);
    drive(1'b0, 12'h0, 2'd0, 1'b0);
    #2;
    chk("async_rst_vld", data_valid, 1'b0);
    chk("async_rst_dat", data_out, MID);
    tick();
    step(1'b0, 12'h0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 12'h0, 2'd0, 1'b1);
      chk("post_rst_vld", data_valid, 1'b0);
    end

`ifdef DDS_PTA_DITHER_EN
    begin
      int         changes;
      logic [9:0] first;
      logic       have;
      changes = 0;
      have    = 1'b0;
      first   = MID;
      step(1'b0, 12'h0, 2'd0, 1'b0);
      for (int i = 0; i < 103; i++) begin
        step(i < 100, 12'h001, 2'd0, 1'b1);
        if (data_valid) begin
          if (!have) begin
            first = data_out;
            have  = 1'b1;
          end else if (data_out != first) begin
            changes++;
          end
        end
      end
      chk("dith_nonconst", changes > 0, 1'b1);
    end
`endif

    repeat (2) step(1'b0, 12'h0, 2'd0, 1'b1);
    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
